// File: rtl/axi_4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite command/response master.
package axi_4_lite_pkg;

    // Master sequencing states; exactly one transaction is in flight at a time.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RSP = 3'd2,
        RD_REQ = 3'd3,
        RD_RSP = 3'd4,
        DONE   = 3'd5
    } axi_state_e;

    // AXI response encodings.
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Unprivileged, secure, data access.
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_4_lite_master_if.sv
// AXI4-Lite bus bundle; signal names match the register slave it connects to.
interface axi_4_lite_master_if #(
    parameter int unsigned AXI_Dwidth    = 32,
    parameter int unsigned AXI_Addrwidth = 4
);
    logic [AXI_Addrwidth-1:0]  AXI_awaddr;
    logic                      AXI_awvalid;
    logic                      AXI_awready;
    logic [AXI_Dwidth-1:0]     AXI_wdata;
    logic [AXI_Dwidth/8-1:0]   AXI_wstrb;
    logic                      AXI_wvalid;
    logic                      AXI_wready;
    logic [1:0]                AXI_bresp;
    logic                      AXI_bvalid;
    logic                      AXI_bready;
    logic [AXI_Addrwidth-1:0]  AXI_areadaddr;
    logic [2:0]                AXI_arprotect;
    logic                      AXI_arvalid;
    logic                      AXI_arready;
    logic [AXI_Dwidth-1:0]     AXI_rdata;
    logic [1:0]                AXI_rresp;
    logic                      AXI_rvalid;
    logic                      AXI_rready;

    modport master (
        output AXI_awaddr, AXI_awvalid,
        input  AXI_awready,
        output AXI_wdata, AXI_wstrb, AXI_wvalid,
        input  AXI_wready,
        input  AXI_bresp, AXI_bvalid,
        output AXI_bready,
        output AXI_areadaddr, AXI_arprotect, AXI_arvalid,
        input  AXI_arready,
        input  AXI_rdata, AXI_rresp, AXI_rvalid,
        output AXI_rready
    );

    modport slave (
        input  AXI_awaddr, AXI_awvalid,
        output AXI_awready,
        input  AXI_wdata, AXI_wstrb, AXI_wvalid,
        output AXI_wready,
        output AXI_bresp, AXI_bvalid,
        input  AXI_bready,
        input  AXI_areadaddr, AXI_arprotect, AXI_arvalid,
        output AXI_arready,
        output AXI_rdata, AXI_rresp, AXI_rvalid,
        input  AXI_rready
    );

endinterface

// File: rtl/axi_lite_timeout_ctr.sv
// Watchdog counter: counts while enabled, clears on request, flags the cycle
// in which the count reaches LIMIT.
module axi_lite_timeout_ctr #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired_o = en_i && (count_q == CNT_W'(LIMIT - 1));

    // Next count: clear wins, stop once expired so the count never wraps.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axi_4_lite_master.sv
// Single-outstanding AXI4-Lite master: command handshake in, AXI4-Lite read or
// write transaction out, result returned on a response handshake.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN.
module axi_4_lite_master
    import axi_4_lite_pkg::*;
#(
    parameter int unsigned AXI_Dwidth     = 32,
    parameter int unsigned AXI_Addrwidth  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     AXI_aclk,
    input  logic                     AXI_aresetn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_rnw,
    input  logic [AXI_Addrwidth-1:0] cmd_addr,
    input  logic [AXI_Dwidth-1:0]    cmd_wdata,
    input  logic [AXI_Dwidth/8-1:0]  cmd_wstrb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [AXI_Dwidth-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic                     rsp_rnw,
    output logic                     rsp_timeout,
    axi_4_lite_master_if.master      axi
);

    if (AXI_Dwidth != 32 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("axi_4_lite_master: AXI_Dwidth must be 32 and TIMEOUT_CYCLES nonzero");
    end

    axi_state_e                 state_q, state_d;
    logic                       run_q;
    logic                       awvalid_q, awvalid_d;
    logic                       wvalid_q, wvalid_d;
    logic                       bready_q, bready_d;
    logic                       arvalid_q, arvalid_d;
    logic                       rready_q, rready_d;
    logic [AXI_Addrwidth-1:0]   awaddr_q, awaddr_d;
    logic [AXI_Dwidth-1:0]      wdata_q, wdata_d;
    logic [AXI_Dwidth/8-1:0]    wstrb_q, wstrb_d;
    logic [AXI_Addrwidth-1:0]   araddr_q, araddr_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [AXI_Dwidth-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                 rsp_resp_q, rsp_resp_d;
    logic                       rsp_rnw_q, rsp_rnw_d;
    logic                       aw_done, w_done;

`ifdef AXI_MASTER_TIMEOUT_EN
    logic                       rsp_timeout_q, rsp_timeout_d;
    logic                       wdog_en;
    logic                       wdog_expired;

    assign wdog_en = (state_q == WR_REQ) || (state_q == WR_RSP) ||
                     (state_q == RD_REQ) || (state_q == RD_RSP);

    axi_lite_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i     (AXI_aclk),
        .rstn_i    (AXI_aresetn),
        .clr_i     (!wdog_en),
        .en_i      (wdog_en),
        .expired_o (wdog_expired)
    );

    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    // run_q holds cmd_ready low during reset and releases it one cycle after.
    assign cmd_ready = run_q && (state_q == IDLE);

    assign axi.AXI_awaddr    = awaddr_q;
    assign axi.AXI_awvalid   = awvalid_q;
    assign axi.AXI_wdata     = wdata_q;
    assign axi.AXI_wstrb     = wstrb_q;
    assign axi.AXI_wvalid    = wvalid_q;
    assign axi.AXI_bready    = bready_q;
    assign axi.AXI_areadaddr = araddr_q;
    assign axi.AXI_arprotect = AXI_PROT_DEFAULT;
    assign axi.AXI_arvalid   = arvalid_q;
    assign axi.AXI_rready    = rready_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_rnw   = rsp_rnw_q;

    // Next-state and next-output decode; every AXI/rsp output is computed here
    // one cycle ahead so the outputs themselves come straight from flops.
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        araddr_d    = araddr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_rnw_d   = rsp_rnw_q;
        aw_done     = 1'b0;
        w_done      = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    rsp_rnw_d = cmd_rnw;
`ifdef AXI_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    if (cmd_rnw) begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end else begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end
                end
            end

            WR_REQ: begin
                // A channel is done if its handshake already happened
                // (valid dropped) or happens on this edge.
                aw_done = !awvalid_q || axi.AXI_awready;
                w_done  = !wvalid_q  || axi.AXI_wready;
                if (awvalid_q && axi.AXI_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && axi.AXI_wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WR_RSP;
                end
            end

            WR_RSP: begin
                if (axi.AXI_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = axi.AXI_bresp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            RD_REQ: begin
                if (axi.AXI_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RSP;
                end
            end

            RD_RSP: begin
                if (axi.AXI_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = axi.AXI_rresp;
                    rsp_rdata_d = axi.AXI_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef AXI_MASTER_TIMEOUT_EN
        // Expiry overrides whatever the busy state decided this cycle.
        if (wdog_expired) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_resp_d    = SLVERR;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
            rsp_valid_d   = 1'b1;
            state_d       = DONE;
        end
`endif
    end

    // State and output registers; reset clears everything and drops any command.
    always_ff @(posedge AXI_aclk) begin
        if (!AXI_aresetn) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_rnw_q   <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            araddr_q    <= araddr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_rnw_q   <= rsp_rnw_d;
`ifdef AXI_MASTER_TIMEOUT_EN
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi_4_lite_master.sv
// Directed bench for axi_4_lite_master against a configurable four-register
// slave model (reg0 = LED, reg1 = SW read-only, reg2/reg3 = scratch).
module tb_axi_4_lite_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rnw = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_rnw;
    logic        rsp_timeout;

    always #5 clk = ~clk;

    axi_4_lite_master_if #(.AXI_Dwidth(32), .AXI_Addrwidth(4)) axi_bus ();

    axi_4_lite_master #(
        .AXI_Dwidth     (32),
        .AXI_Addrwidth  (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .AXI_aclk    (clk),
        .AXI_aresetn (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rnw     (cmd_rnw),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_rnw     (rsp_rnw),
        .rsp_timeout (rsp_timeout),
        .axi         (axi_bus)
    );

    // ---------------- slave model ----------------
    int          aw_lat = 1, w_lat = 1, ar_lat = 1, b_lat = 1, r_lat = 1;
    logic [1:0]  bresp_f = 2'b00, rresp_f = 2'b00;
    logic        ar_stuck = 1'b0;
    logic [3:0]  sw = 4'h0;
    logic [31:0] regs [4];
    logic        awready_q, wready_q, arready_q, bvalid_q, rvalid_q;
    logic [31:0] rdata_q;
    int          aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
    logic        aw_got, w_got;
    logic [3:0]  aw_a;
    logic [31:0] w_d;
    logic [3:0]  w_s;
    logic [3:0]  led;

    assign led = regs[0][3:0];
    assign axi_bus.AXI_awready = (aw_lat == 0) || awready_q;
    assign axi_bus.AXI_wready  = (w_lat == 0) || wready_q;
    assign axi_bus.AXI_arready = !ar_stuck && ((ar_lat == 0) || arready_q);
    assign axi_bus.AXI_bvalid  = bvalid_q;
    assign axi_bus.AXI_bresp   = bresp_f;
    assign axi_bus.AXI_rvalid  = rvalid_q;
    assign axi_bus.AXI_rresp   = rresp_f;
    assign axi_bus.AXI_rdata   = rdata_q;

    always @(posedge clk) begin : slave
        logic aw_hs, w_hs, ar_hs, have_aw, have_w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [1:0]  ri;
        if (!rst_n) begin
            awready_q <= 1'b0; wready_q <= 1'b0; arready_q <= 1'b0;
            bvalid_q <= 1'b0; rvalid_q <= 1'b0; rdata_q <= '0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0; w_s <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            aw_hs = axi_bus.AXI_awvalid && axi_bus.AXI_awready;
            w_hs  = axi_bus.AXI_wvalid && axi_bus.AXI_wready;
            ar_hs = axi_bus.AXI_arvalid && axi_bus.AXI_arready;
            if (axi_bus.AXI_awvalid && !axi_bus.AXI_awready) begin
                if (aw_cnt + 1 >= aw_lat) begin awready_q <= 1'b1; aw_cnt <= 0; end
                else aw_cnt <= aw_cnt + 1;
            end
            if (aw_hs) awready_q <= 1'b0;
            if (axi_bus.AXI_wvalid && !axi_bus.AXI_wready) begin
                if (w_cnt + 1 >= w_lat) begin wready_q <= 1'b1; w_cnt <= 0; end
                else w_cnt <= w_cnt + 1;
            end
            if (w_hs) wready_q <= 1'b0;
            if (axi_bus.AXI_arvalid && !axi_bus.AXI_arready && !ar_stuck) begin
                if (ar_cnt + 1 >= ar_lat) begin arready_q <= 1'b1; ar_cnt <= 0; end
                else ar_cnt <= ar_cnt + 1;
            end
            if (ar_hs) arready_q <= 1'b0;

            have_aw = aw_got || aw_hs;
            have_w  = w_got || w_hs;
            a = aw_hs ? axi_bus.AXI_awaddr : aw_a;
            d = w_hs ? axi_bus.AXI_wdata : w_d;
            s = w_hs ? axi_bus.AXI_wstrb : w_s;
            if (aw_hs) begin aw_got <= 1'b1; aw_a <= axi_bus.AXI_awaddr; end
            if (w_hs) begin w_got <= 1'b1; w_d <= axi_bus.AXI_wdata; w_s <= axi_bus.AXI_wstrb; end

            if (bvalid_q && axi_bus.AXI_bready) bvalid_q <= 1'b0;
            if (b_wait == 1) begin bvalid_q <= 1'b1; b_wait <= 0; end
            else if (b_wait > 1) b_wait <= b_wait - 1;
            if (have_aw && have_w) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                if (a[3:2] != 2'd1) begin
                    for (int i = 0; i < 4; i++)
                        if (s[i]) regs[a[3:2]][8*i +: 8] <= d[8*i +: 8];
                end
                if (b_lat <= 1) bvalid_q <= 1'b1;
                else b_wait <= b_lat - 1;
            end

            if (rvalid_q && axi_bus.AXI_rready) rvalid_q <= 1'b0;
            if (r_wait == 1) begin rvalid_q <= 1'b1; r_wait <= 0; end
            else if (r_wait > 1) r_wait <= r_wait - 1;
            if (ar_hs) begin
                ri = axi_bus.AXI_areadaddr[3:2];
                rdata_q <= (ri == 2'd1) ? {28'h0, sw} : regs[ri];
                if (r_lat <= 1) rvalid_q <= 1'b1;
                else r_wait <= r_lat - 1;
            end
        end
    end

    // ---------------- protocol monitor ----------------
    int          viol = 0;
    int          hs = 0;
    logic        p_rst = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
    logic        p_arv = 1'b0, p_arr = 1'b0;
    logic [3:0]  p_awaddr = '0, p_araddr = '0, p_wstrb = '0;
    logic [31:0] p_wdata = '0;

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) hs++;
        if (rst_n && p_rst) begin
            if (p_awv && !p_awr && (!axi_bus.AXI_awvalid || axi_bus.AXI_awaddr != p_awaddr)) viol++;
            if (p_wv && !p_wr && (!axi_bus.AXI_wvalid || axi_bus.AXI_wdata != p_wdata ||
                                  axi_bus.AXI_wstrb != p_wstrb)) viol++;
            if (p_arv && !p_arr && (!axi_bus.AXI_arvalid || axi_bus.AXI_areadaddr != p_araddr)) viol++;
        end
        p_rst = rst_n;
        p_awv = axi_bus.AXI_awvalid; p_awr = axi_bus.AXI_awready; p_awaddr = axi_bus.AXI_awaddr;
        p_wv = axi_bus.AXI_wvalid; p_wr = axi_bus.AXI_wready;
        p_wdata = axi_bus.AXI_wdata; p_wstrb = axi_bus.AXI_wstrb;
        p_arv = axi_bus.AXI_arvalid; p_arr = axi_bus.AXI_arready; p_araddr = axi_bus.AXI_areadaddr;
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command, wait for its result, optionally stall rsp_ready.
    // lat counts clock edges from the accepting edge to rsp_valid visible.
    task automatic do_cmd(input logic rnw, input logic [3:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input int stall, input logic [1:0] stall_rs,
                          output logic [31:0] rd, output logic [1:0] rs, output logic rn,
                          output logic to, output int lat);
        int n;
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("rsp_valid_wait", rsp_valid, 1);
        rd = rsp_rdata; rs = rsp_resp; rn = rsp_rnw; to = rsp_timeout;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", rsp_valid, 1);
            chk("stall_resp", rsp_resp, stall_rs);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        rn, to;
        int          lat, n, hs0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_awvalid", axi_bus.AXI_awvalid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        chk("rel_cmd_ready_same_cycle", cmd_ready, 0);
        @(posedge clk); #1;
        chk("rel_cmd_ready_next", cmd_ready, 1);

        // Write LED register; rsp_valid lands in cycle N+4 (3 edges after accept).
        do_cmd(1'b0, 4'h0, 32'h0000_000A, 4'hF, 0, 2'b00, rd, rs, rn, to, lat);
        chk("w0_resp", rs, 2'b00);
        chk("w0_rnw", rn, 0);
        chk("w0_rdata", rd, 0);
        chk("w0_to", to, 0);
        chk("w0_lat", lat, 3);
        chk("led", led, 4'hA);

        sw = 4'h5;
        do_cmd(1'b1, 4'h4, 32'h0, 4'h0, 0, 2'b00, rd, rs, rn, to, lat);
        chk("r4_rdata", rd, 32'h0000_0005);
        chk("r4_resp", rs, 2'b00);
        chk("r4_rnw", rn, 1);
        chk("r4_lat", lat, 3);

        do_cmd(1'b0, 4'h8, 32'hDEAD_BEEF, 4'hF, 0, 2'b00, rd, rs, rn, to, lat);
        chk("w8a_rdata_zero", rd, 0);
        do_cmd(1'b0, 4'h8, 32'h0000_0011, 4'h1, 0, 2'b00, rd, rs, rn, to, lat);
        chk("w8b_resp", rs, 2'b00);
        do_cmd(1'b1, 4'h8, 32'h0, 4'h0, 0, 2'b00, rd, rs, rn, to, lat);
        chk("r8_strobe_merge", rd, 32'hDEAD_BE11);

        // Late AWREADY, immediate WREADY, slow SLVERR response, stalled consumer.
        hs0 = hs;
        aw_lat = 3; w_lat = 0; b_lat = 5; bresp_f = 2'b10;
        do_cmd(1'b0, 4'hC, 32'h0000_0077, 4'hF, 4, 2'b10, rd, rs, rn, to, lat);
        chk("slow_resp", rs, 2'b10);
        chk("slow_lat", lat, 9);
        repeat (2) @(posedge clk);
        #1;
        chk("slow_single_handshake", hs - hs0, 1);
        aw_lat = 1; w_lat = 1; b_lat = 1; bresp_f = 2'b00;
        do_cmd(1'b1, 4'hC, 32'h0, 4'h0, 0, 2'b00, rd, rs, rn, to, lat);
        chk("rC_after_slow", rd, 32'h0000_0077);

        // DECERR on read passes through, next command is unaffected.
        rresp_f = 2'b11;
        do_cmd(1'b1, 4'h0, 32'h0, 4'h0, 0, 2'b00, rd, rs, rn, to, lat);
        chk("decerr_resp", rs, 2'b11);
        chk("decerr_rdata", rd, 32'h0000_000A);
        rresp_f = 2'b00;
        do_cmd(1'b1, 4'h4, 32'h0, 4'h0, 0, 2'b00, rd, rs, rn, to, lat);
        chk("after_decerr_resp", rs, 2'b00);
        chk("after_decerr_rdata", rd, 32'h0000_0005);

        // Reset pulse while waiting in WR_RSP.
        hs0 = hs;
        b_lat = 6;
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 4'h8;
        cmd_wdata = 32'h5555_5555; cmd_wstrb = 4'hF;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("rstmid_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!axi_bus.AXI_bready && n < 50) begin @(posedge clk); #1; n++; end
        chk("rstmid_in_wr_rsp", axi_bus.AXI_bready, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rstmid_cmd_ready0", cmd_ready, 0);
        chk("rstmid_awvalid", axi_bus.AXI_awvalid, 0);
        chk("rstmid_wvalid", axi_bus.AXI_wvalid, 0);
        chk("rstmid_bready", axi_bus.AXI_bready, 0);
        chk("rstmid_arvalid", axi_bus.AXI_arvalid, 0);
        chk("rstmid_rready", axi_bus.AXI_rready, 0);
        chk("rstmid_awaddr", axi_bus.AXI_awaddr, 0);
        chk("rstmid_wdata", axi_bus.AXI_wdata, 0);
        chk("rstmid_wstrb", axi_bus.AXI_wstrb, 0);
        chk("rstmid_araddr", axi_bus.AXI_areadaddr, 0);
        chk("rstmid_arprot", axi_bus.AXI_arprotect, 0);
        chk("rstmid_rsp_valid", rsp_valid, 0);
        chk("rstmid_rsp_rdata", rsp_rdata, 0);
        chk("rstmid_rsp_resp", rsp_resp, 0);
        chk("rstmid_rsp_rnw", rsp_rnw, 0);
        chk("rstmid_rsp_timeout", rsp_timeout, 0);
        @(posedge clk); #1;
        chk("rstmid_cmd_ready1", cmd_ready, 1);
        chk("rstmid_no_handshake", hs - hs0, 0);
        b_lat = 1;
        do_cmd(1'b0, 4'hC, 32'hCAFE_0001, 4'hF, 0, 2'b00, rd, rs, rn, to, lat);
        chk("post_rst_w_resp", rs, 2'b00);
        chk("post_rst_w_lat", lat, 3);
        do_cmd(1'b1, 4'hC, 32'h0, 4'h0, 0, 2'b00, rd, rs, rn, to, lat);
        chk("post_rst_readback", rd, 32'hCAFE_0001);

`ifdef AXI_MASTER_TIMEOUT_EN
        // ARREADY never arrives: watchdog fires after 16 busy cycles.
        ar_stuck = 1'b1;
        do_cmd(1'b1, 4'h0, 32'h0, 4'h0, 0, 2'b00, rd, rs, rn, to, lat);
        chk("wdog_timeout", to, 1);
        chk("wdog_resp", rs, 2'b10);
        chk("wdog_rdata", rd, 0);
        chk("wdog_lat", lat, 16);
        ar_stuck = 1'b0;
        do_cmd(1'b1, 4'h4, 32'h0, 4'h0, 0, 2'b00, rd, rs, rn, to, lat);
        chk("wdog_after_to", to, 0);
        chk("wdog_after_rdata", rd, 32'h0000_0005);
`endif

        chk("protocol_violations", viol, 0);
        chk("arprot_const", axi_bus.AXI_arprotect, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
